// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Latency ~INHIBIT_CYCLES + 11 keyboard clocks; start ignored while busy, no other backpressure.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic             clk_s1, clk_s2, clk_s3;
  logic             dat_s1, dat_s2;
  logic             clk_fall;
  logic             line_idle;
  logic             timeout;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       edge_cnt;
  logic [9:0]       frame;
  logic             dat_drv;
  logic             nack;

  // clk_s3 is the previous synchronized clock, used only for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_dat_in;
      dat_s2 <= dat_s1;
    end
  end

  assign clk_fall  = clk_s3 & ~clk_s2;
  assign line_idle = clk_s2 & dat_s2;
  assign timeout   = (state inside {REQUEST, SHIFT, ACK, WAIT_IDLE}) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = INHIBIT;
      INHIBIT:   if (inh_cnt == INH_LAST) state_nxt = REQUEST;
      REQUEST: begin
        if (timeout)       state_nxt = IDLE;
        else if (clk_fall) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (timeout)                            state_nxt = IDLE;
        else if (clk_fall && edge_cnt == 4'd9)  state_nxt = ACK;
      end
      ACK: begin
        if (timeout)       state_nxt = IDLE;
        else if (clk_fall) state_nxt = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (timeout || line_idle) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // frame is {stop, parity, data} and shifts out LSB first, one bit per falling edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inh_cnt  <= '0;
      to_cnt   <= '0;
      edge_cnt <= '0;
      frame    <= '0;
      dat_drv  <= 1'b0;
      nack     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            frame    <= {1'b1, ~^cmd, cmd};
            edge_cnt <= '0;
            inh_cnt  <= '0;
          end
        end
        INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          to_cnt  <= '0;
        end
        REQUEST, SHIFT: begin
          to_cnt <= to_cnt + 1'b1;
          if (clk_fall && edge_cnt < 4'd10) begin
            dat_drv  <= ~frame[0];
            frame    <= {1'b0, frame[9:1]};
            edge_cnt <= edge_cnt + 1'b1;
          end
        end
        ACK: begin
          to_cnt <= to_cnt + 1'b1;
          if (clk_fall) begin
            nack     <= dat_s2;
            edge_cnt <= 4'd11;
          end
        end
        WAIT_IDLE: to_cnt <= to_cnt + 1'b1;
        default: ;
      endcase
      if (timeout) begin
        error <= 1'b1;
      end else if (state == WAIT_IDLE && line_idle) begin
        done  <= ~nack;
        error <= nack;
      end
    end
  end

  // last INHIBIT cycle overlaps data low with clock low to form the request-to-send
  assign ps2_clk_oe = (state == INHIBIT);
  assign ps2_dat_oe = ((state == INHIBIT) && (inh_cnt == INH_LAST)) ||
                      (state == REQUEST) ||
                      ((state == SHIFT) && dat_drv);
  assign busy       = (state != IDLE);

endmodule
